// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported, combinational-read
// data memory. Each port gets a one-cycle response pulse and a grant counter.

module dmem_arb_lane #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              we,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  grants
);
  logic resp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= 1'b0;
      rdata  <= '0;
      grants <= '0;
    end else begin
      resp_q <= accept;
      if (accept) begin
        rdata  <= we ? '0 : mem_read_data;
        grants <= grants + 1'b1;
      end
    end
  end

  // A pulse already queued when reset arrives must not reach the requester.
  assign resp_valid = resp_q & ~rst;
endmodule

module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_we,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_resp_valid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [CNT_W-1:0]  p0_grants,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_we,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_resp_valid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [CNT_W-1:0]  p1_grants,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]             valid, ready, we, resp_valid;
  logic [NUM_LANES-1:0][ADDR_W-1:0] addr;
  logic [NUM_LANES-1:0][DATA_W-1:0] wdata, rdata;
  logic [NUM_LANES-1:0][CNT_W-1:0]  grants;
  logic                             last_grant;

  assign valid = {p1_valid, p0_valid};
  assign we    = {p1_we, p0_we};
  assign addr  = {p1_addr, p0_addr};
  assign wdata = {p1_wdata, p0_wdata};

  // Port 0 wins unless port 1 is also asking and port 0 was granted last.
  always_comb begin
    ready = '0;
    if (!rst) begin
      if (valid[0] && (!valid[1] || last_grant)) ready[0] = 1'b1;
      else if (valid[1])                         ready[1] = 1'b1;
    end
  end

  always_comb begin
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (ready[i]) begin
        mem_address      = addr[i];
        mem_write_data   = wdata[i];
        mem_write_enable = we[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         last_grant <= 1'b1;
    else if (|ready) last_grant <= ready[1];
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dmem_arb_lane #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane (
      .clk           (clk),
      .rst           (rst),
      .accept        (ready[g]),
      .we            (we[g]),
      .mem_read_data (mem_read_data),
      .resp_valid    (resp_valid[g]),
      .rdata         (rdata[g]),
      .grants        (grants[g])
    );
  end

  assign p0_ready      = ready[0];
  assign p1_ready      = ready[1];
  assign p0_resp_valid = resp_valid[0];
  assign p1_resp_valid = resp_valid[1];
  assign p0_rdata      = rdata[0];
  assign p1_rdata      = rdata[1];
  assign p0_grants     = grants[0];
  assign p1_grants     = grants[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus a
// cycle-by-cycle reference model of arbitration, memory and responses.

module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p1_valid, p0_we, p1_we;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic        p0_ready, p1_ready, p0_resp_valid, p1_resp_valid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [3:0]  p0_grants, p1_grants;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_we(p0_we),
    .p0_wdata(p0_wdata), .p0_resp_valid(p0_resp_valid), .p0_rdata(p0_rdata),
    .p0_grants(p0_grants),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_we(p1_we),
    .p1_wdata(p1_wdata), .p1_resp_valid(p1_resp_valid), .p1_rdata(p1_rdata),
    .p1_grants(p1_grants),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'h1234_5678 : (a ^ 32'h5A5A_0000);
  endfunction

  // Physical memory driven by the DUT; unwritten words return init_val().
  logic [31:0]  pmem [256];
  logic [255:0] pwr = '0;
  always_comb begin
    mem_read_data = pwr[mem_address[7:0]] ? pmem[mem_address[7:0]] : init_val(mem_address);
  end
  always @(posedge clk) begin
    if (mem_write_enable) begin
      pmem[mem_address[7:0]] <= mem_write_data;
      pwr[mem_address[7:0]]  <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who wins a tie, pending responses, counters, memory image.
  int          prio = 0;
  logic [1:0]  pend = '0;
  logic [31:0] prdata [2] = '{32'd0, 32'd0};
  int          cnt [2] = '{0, 0};
  int          wt [2]  = '{0, 0};
  logic [31:0] mmem [256];
  logic [255:0] mwr = '0;

  initial begin
    logic v0, v1, g0, g1, gw;
    logic [31:0] ga, gd, rd;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        v0 = p0_valid & ~rst;
        v1 = p1_valid & ~rst;
        g0 = v0 && (!v1 || prio == 0);
        g1 = v1 && !g0;
        ga = g0 ? p0_addr  : (g1 ? p1_addr  : 32'd0);
        gd = g0 ? p0_wdata : (g1 ? p1_wdata : 32'd0);
        gw = g0 ? p0_we    : (g1 ? p1_we    : 1'b0);
        chk("p0_ready", 32'(p0_ready), 32'(g0));
        chk("p1_ready", 32'(p1_ready), 32'(g1));
        chk("mem_address", mem_address, ga);
        chk("mem_write_data", mem_write_data, gd);
        chk("mem_write_enable", 32'(mem_write_enable), 32'(gw));
        chk("p0_resp_valid", 32'(p0_resp_valid), 32'(pend[0] & ~rst));
        chk("p1_resp_valid", 32'(p1_resp_valid), 32'(pend[1] & ~rst));
        chk("p0_rdata", p0_rdata, prdata[0]);
        chk("p1_rdata", p1_rdata, prdata[1]);
        chk("p0_grants", 32'(p0_grants), 32'(cnt[0]));
        chk("p1_grants", 32'(p1_grants), 32'(cnt[1]));
        wt[0] = (v0 && !g0) ? wt[0] + 1 : 0;
        wt[1] = (v1 && !g1) ? wt[1] + 1 : 0;
        if (v0) chk("p0_starve", 32'(wt[0] <= 1), 32'd1);
        if (v1) chk("p1_starve", 32'(wt[1] <= 1), 32'd1);
        if (rst) begin
          prio = 0; pend = '0; prdata[0] = '0; prdata[1] = '0; cnt[0] = 0; cnt[1] = 0;
        end else begin
          pend = {g1, g0};
          if (g0 || g1) begin
            if (gw) begin
              mmem[ga[7:0]] = gd;
              mwr[ga[7:0]]  = 1'b1;
              rd = '0;
            end else begin
              rd = mwr[ga[7:0]] ? mmem[ga[7:0]] : init_val(ga);
            end
            prdata[g1 ? 1 : 0] = rd;
            cnt[g1 ? 1 : 0] = (cnt[g1 ? 1 : 0] + 1) % 16;
            prio = g0 ? 1 : 0;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_valid = 0; p1_valid = 0; p0_we = 0; p1_we = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  initial begin
    logic [5:0] seq;
    int npulse;
    rst = 1;
    idle();
    p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
    cyc();
    chk_en = 1;
    #2;
    chk("rst_p0_grants", 32'(p0_grants), 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    chk("rst_resp", 32'(p0_resp_valid | p1_resp_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_write_enable), 32'd0);
    cyc();
    rst = 0;

    // Single read from preloaded address.
    p0_valid = 1; p0_addr = 32'h10; p0_we = 0;
    #2 chk("t1_ready", 32'(p0_ready), 32'd1);
    cyc(); idle();
    #2 chk("t1_resp", 32'(p0_resp_valid), 32'd1);
    chk("t1_rdata", p0_rdata, 32'h1234_5678);
    chk("t1_grants", 32'(p0_grants), 32'd1);
    cyc();

    // Write followed by read of the same word on port 1.
    p1_valid = 1; p1_addr = 32'h20; p1_we = 1; p1_wdata = 32'hCAFE_F00D;
    #2 chk("t2_wr_ready", 32'(p1_ready), 32'd1);
    chk("t2_mem_we", 32'(mem_write_enable), 32'd1);
    cyc();
    p1_we = 0;
    #2 chk("t2_wr_resp", 32'(p1_resp_valid), 32'd1);
    chk("t2_wr_rdata", p1_rdata, 32'd0);
    cyc(); idle();
    #2 chk("t2_rd_resp", 32'(p1_resp_valid), 32'd1);
    chk("t2_rd_rdata", p1_rdata, 32'hCAFE_F00D);
    cyc();

    // Continuous conflict after reset alternates starting with port 0.
    do_reset();
    seq = 6'b010101;
    p0_valid = 1; p1_valid = 1; p0_addr = 32'h31; p1_addr = 32'h32;
    for (int i = 0; i < 6; i++) begin
      #2 chk("t3_p0_turn", 32'(p0_ready), 32'(seq[i]));
      cyc();
    end
    idle();
    #2 chk("t3_p0_grants", 32'(p0_grants), 32'd3);
    chk("t3_p1_grants", 32'(p1_grants), 32'd3);
    cyc();

    // Single requester streams every cycle.
    do_reset();
    npulse = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin p0_valid = 1; p0_addr = 32'(i); end
      else idle();
      #2;
      if (i < 8) chk("t4_ready", 32'(p0_ready), 32'd1);
      if (p0_resp_valid) npulse++;
      cyc();
    end
    #2 chk("t4_pulses", 32'(npulse), 32'd8);
    chk("t4_grants", 32'(p0_grants), 32'd8);
    cyc();

    // Reset right after a read is accepted swallows its response.
    p1_valid = 1; p1_addr = 32'h30; p1_we = 0;
    #2 chk("t5_ready", 32'(p1_ready), 32'd1);
    cyc();
    idle(); rst = 1;
    p0_valid = 1; p0_we = 1; p0_addr = 32'h40; p0_wdata = 32'h1;
    #2 chk("t5_resp", 32'(p1_resp_valid), 32'd0);
    chk("t5_mem_we", 32'(mem_write_enable), 32'd0);
    chk("t5_p0_ready", 32'(p0_ready), 32'd0);
    cyc();
    rst = 0; idle();
    #2 chk("t5_p1_grants", 32'(p1_grants), 32'd0);
    chk("t5_p0_grants", 32'(p0_grants), 32'd0);
    chk("t5_p1_rdata", p1_rdata, 32'd0);
    cyc();

    // Four-bit counter wraps after 16 grants.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      p0_valid = 1; p0_we = i[0]; p0_addr = 32'(8'h80 + i); p0_wdata = 32'(i);
      #2;
      if (i == 15) chk("t6_cnt15", 32'(p0_grants), 32'd15);
      if (i == 16) chk("t6_cnt_wrap", 32'(p0_grants), 32'd0);
      cyc();
    end
    idle();
    #2 chk("t6_grants", 32'(p0_grants), 32'd1);
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: width of request and memory addresses.
REQ-002 Parameter DATA_W, default 32: width of write and read data.
REQ-003 Parameter CNT_W, default 16: width of each grant counter.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Ports p0_valid / p1_valid  input  1: requester N presents a transaction.
REQ-007 Ports p0_ready / p1_ready  output  1: requester N granted this cycle.
REQ-008 Ports p0_addr / p1_addr  input  ADDR_W: word address.
REQ-009 Ports p0_we / p1_we  input  1: 1 = write, 0 = read.
REQ-010 Ports p0_wdata / p1_wdata  input  DATA_W: write data.
REQ-011 Ports p0_resp_valid / p1_resp_valid  output  1: one-cycle completion pulse.
REQ-012 Ports p0_rdata / p1_rdata  output  DATA_W: read result, valid with resp_valid.
REQ-013 Port mem_address  output  ADDR_W: to data memory address.
REQ-014 Port mem_write_data  output  DATA_W: to data memory write_data.
REQ-015 Port mem_write_enable  output  1: to data memory write_enable.
REQ-016 Port mem_read_data  input  DATA_W: combinational read data from data memory.
REQ-017 Ports p0_grants / p1_grants  output  CNT_W: accepted-transaction counts.

Function
REQ-018 Handshake: transaction accepted in cycle N iff pN_valid and pN_ready both high in N.
REQ-019 pN_ready is combinational; at most one of p0_ready, p1_ready high per cycle; never high while pN_valid low or rst high.
REQ-020 Arbitration: one requester valid -> it is granted; both valid -> the port not recorded in last_grant is granted (round-robin).
REQ-021 last_grant register updates to the granted port on every acceptance; holds when nothing accepted.
REQ-022 Accepted cycle: mem_address = granted addr, mem_write_data = granted wdata, mem_write_enable = granted we; no acceptance -> all three driven 0.
REQ-023 Read accepted in N: mem_read_data sampled at end of N; pN_rdata holds it and pN_resp_valid = 1 during N+1 only.
REQ-024 Write accepted in N: memory updated at end of N; pN_resp_valid = 1 during N+1; pN_rdata = 0 that cycle.
REQ-025 Response pulses cannot be back-pressured; requester not granted gets resp_valid = 0.
REQ-026 pN_rdata holds its last value when resp_valid low, except write responses clear it to 0.
REQ-027 Throughput: one accepted transaction per cycle sustained; back-to-back grants to alternating ports allowed.
REQ-028 Single valid requester may be granted every cycle (no forced idle).
REQ-029 pN_grants increments by 1 per accepted transaction of port N; wraps from 2^CNT_W-1 to 0.
REQ-030 Requester holds valid, addr, we, wdata stable until accepted; arbiter behaviour on changes before acceptance is unspecified but shall not grant a dropped request.
REQ-031 Starvation bound: a continuously valid port is granted within 2 cycles.

Reset
REQ-032 rst high at a rising edge: last_grant = port 1 (port 0 wins first conflict), p0/p1_resp_valid = 0, p0/p1_rdata = 0, p0/p1_grants = 0.
REQ-033 While rst high: p0_ready = p1_ready = 0, mem_write_enable = 0, mem_address = 0, mem_write_data = 0.
REQ-034 Reset mid-transaction: a response due in the cycle after rst is suppressed (resp_valid = 0); no memory write issued during rst.

Verification
REQ-035 Single read: p0 read addr 0x10 (mem holds 0x1234_5678) -> p0_ready in N, p0_resp_valid with p0_rdata = 0x1234_5678 in N+1, p0_grants = 1.
REQ-036 Write then read: p1 write 0x20 <- 0xCAFE_F00D in N, p1 read 0x20 in N+1 -> resp N+1 rdata 0, resp N+2 rdata 0xCAFE_F00D.
REQ-037 Conflict after reset: both valid continuously 6 cycles -> grants p0,p1,p0,p1,p0,p1; p0_grants = p1_grants = 3.
REQ-038 Single requester streaming: p0 valid 8 cycles, p1 idle -> p0_ready high all 8 cycles, 8 resp pulses, p0_grants = 8.
REQ-039 Reset mid-stream: rst asserted the cycle after a p1 read is accepted -> p1_resp_valid stays 0, counters 0, mem_write_enable 0 during rst.
REQ-040 Counter wrap with CNT_W = 4: 17 p0 transactions -> p0_grants = 1.
